// File: rtl/instr_encoder_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader_if
// Purpose  : Bundles the field-level instruction request channel (valid/ready
//            plus decoded fields) and the instruction-memory write port of the
//            instruction encoder/loader.
// Ports    : (interface signals)
//   req_valid   request present                 (master -> slave)
//   req_ready   loader can accept this cycle     (slave  -> master)
//   req_kind    instruction kind 0..12, 13-15 illegal
//   req_rd/rs/rt/shamt/aluop  5-bit register/ALU fields
//   req_imm     17-bit I-type immediate
//   req_target  27-bit JI-type target
//   imem_wren   imem write strobe                (slave  -> master)
//   imem_addr   imem write address, ADDR_W bits
//   imem_data   encoded 32-bit instruction word
// Revision : 1.0 - initial release
// ============================================================================
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_kind;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_shamt;
  logic [4:0]        req_aluop;
  logic [16:0]       req_imm;
  logic [26:0]       req_target;
  logic              imem_wren;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;

  modport master (
    output req_valid, req_kind, req_rd, req_rs, req_rt, req_shamt,
           req_aluop, req_imm, req_target,
    input  req_ready, imem_wren, imem_addr, imem_data
  );

  modport slave (
    input  req_valid, req_kind, req_rd, req_rs, req_rt, req_shamt,
           req_aluop, req_imm, req_target,
    output req_ready, imem_wren, imem_addr, imem_data
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader
// Purpose  : Accepts field-level instruction requests, packs them into 32-bit
//            ISA words (opcode in [31:27]) and writes them sequentially into
//            the instruction memory, starting at BASE_ADDR for each session.
// Ports    :
//   clk_i     system clock, rising edge
//   rst_ni    asynchronous active-low reset
//   start_i   begin a new load session (pulse); wins over finish_i
//   finish_i  end the current session (pulse)
//   bus       request channel + imem write port (slave modport)
//   count_o   words written in this session (ADDR_W+1 bits)
//   err_o     sticky: illegal kind seen this session
//   busy_o    session in LOAD state
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 4096,
  parameter int BASE_ADDR = 0
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  input  wire logic              start_i,
  input  wire logic              finish_i,
  instr_encoder_loader_if.slave  bus,
  output logic [ADDR_W:0]        count_o,
  output logic                   err_o,
  output logic                   busy_o
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LOAD = 2'd1;
  localparam logic [1:0] c_ST_FULL = 2'd2;

  localparam logic [ADDR_W+1:0] c_DEPTH = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   c_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  // Opcodes
  localparam logic [4:0] c_OP_RTYPE    = 5'b00000;
  localparam logic [4:0] c_OP_J        = 5'b00001;
  localparam logic [4:0] c_OP_BNE      = 5'b00010;
  localparam logic [4:0] c_OP_JAL      = 5'b00011;
  localparam logic [4:0] c_OP_JR       = 5'b00100;
  localparam logic [4:0] c_OP_ADDI     = 5'b00101;
  localparam logic [4:0] c_OP_BLT      = 5'b00110;
  localparam logic [4:0] c_OP_SW       = 5'b00111;
  localparam logic [4:0] c_OP_LW       = 5'b01000;
  localparam logic [4:0] c_OP_INCSCORE = 5'b01001;
  localparam logic [4:0] c_OP_SETX     = 5'b10101;
  localparam logic [4:0] c_OP_BEX      = 5'b10110;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              wr_valid_q, wr_valid_d;
  logic [31:0]       data_q, data_d;

  logic [31:0]       enc_w;
  logic              legal_w;
  logic              accept_w;
  logic              wr_fire_w;
  logic [ADDR_W+1:0] occ_q_w;
  logic [ADDR_W+1:0] occ_d_w;

  // ---------------------------------------------------------------------------
  // Field packing. Unused bit positions stay zero.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] f_itype(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  always_comb begin
    enc_w   = 32'h0;
    legal_w = 1'b1;
    unique case (bus.req_kind)
      4'd0:  enc_w = 32'h0;
      4'd1:  enc_w = {c_OP_RTYPE, bus.req_rd, bus.req_rs, bus.req_rt,
                      bus.req_shamt, bus.req_aluop, 2'b00};
      4'd2:  enc_w = f_itype(c_OP_ADDI, bus.req_rd, bus.req_rs, bus.req_imm);
      4'd3:  enc_w = f_itype(c_OP_SW, bus.req_rd, bus.req_rs, bus.req_imm);
      4'd4:  enc_w = f_itype(c_OP_LW, bus.req_rd, bus.req_rs, bus.req_imm);
      4'd5:  enc_w = {c_OP_J, bus.req_target};
      4'd6:  enc_w = f_itype(c_OP_BNE, bus.req_rd, bus.req_rs, bus.req_imm);
      4'd7:  enc_w = {c_OP_JAL, bus.req_target};
      4'd8:  enc_w = {c_OP_JR, bus.req_rd, 22'h0};
      4'd9:  enc_w = f_itype(c_OP_BLT, bus.req_rd, bus.req_rs, bus.req_imm);
      4'd10: enc_w = {c_OP_BEX, bus.req_target};
      4'd11: enc_w = {c_OP_SETX, bus.req_target};
      4'd12: enc_w = f_itype(c_OP_INCSCORE, bus.req_rd, bus.req_rs, bus.req_imm);
      default: begin
        enc_w   = 32'h0;
        legal_w = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake. Occupancy counts the word sitting in the write stage so that
  // exactly DEPTH words can ever be accepted in one session.
  // ---------------------------------------------------------------------------
  assign occ_q_w       = {1'b0, count_q} + {{(ADDR_W+1){1'b0}}, wr_valid_q};
  assign busy_o        = (state_q == c_ST_LOAD);
  assign bus.req_ready = busy_o & ~start_i & (occ_q_w < c_DEPTH);
  assign accept_w      = bus.req_valid & bus.req_ready;

  // A start in the same cycle as a pending write kills that write outright.
  assign wr_fire_w     = wr_valid_q & ~start_i;

  assign bus.imem_wren = wr_fire_w;
  assign bus.imem_addr = c_BASE + count_q[ADDR_W-1:0];
  assign bus.imem_data = data_q;
  assign count_o       = count_q;
  assign err_o         = err_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    err_d      = err_q;
    wr_valid_d = 1'b0;
    data_d     = data_q;

    if (wr_fire_w) begin
      count_d = count_q + c_ONE;
    end

    if (accept_w) begin
      if (legal_w) begin
        wr_valid_d = 1'b1;
        data_d     = enc_w;
      end else begin
        err_d = 1'b1;
      end
    end

    occ_d_w = {1'b0, count_d} + {{(ADDR_W+1){1'b0}}, wr_valid_d};

    unique case (state_q)
      c_ST_LOAD: begin
        if (finish_i) begin
          state_d = c_ST_IDLE;
        end else if (occ_d_w == c_DEPTH) begin
          state_d = c_ST_FULL;
        end
      end
      c_ST_FULL: begin
        if (finish_i) begin
          state_d = c_ST_IDLE;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase

    if (start_i) begin
      state_d    = c_ST_LOAD;
      count_d    = '0;
      err_d      = 1'b0;
      wr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= c_ST_IDLE;
      count_q    <= '0;
      err_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      data_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      err_q      <= err_d;
      wr_valid_q <= wr_valid_d;
      data_q     <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder_loader
// Purpose  : Scoreboard bench for instr_encoder_loader (DEPTH=4, BASE_ADDR=0).
//            Driver pushes hand-computed {addr,data} on every legal accept; a
//            monitor pops and compares on every imem write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst_n;
  logic start;
  logic finish;
  logic [ADDR_W:0] count;
  logic err;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W+31:0] sb_q[$];
  logic [ADDR_W-1:0]  exp_addr;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) ifc ();

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .finish_i (finish),
    .bus      (ifc),
    .count_o  (count),
    .err_o    (err),
    .busy_o   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && ifc.imem_wren) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%03h data 0x%08h, none expected", ifc.imem_addr, ifc.imem_data);
      end else begin
        logic [ADDR_W+31:0] e;
        e = sb_q.pop_front();
        check("imem_addr", 32'(ifc.imem_addr), 32'(e[ADDR_W+31:32]));
        check("imem_data", ifc.imem_data, e[31:0]);
      end
    end
  end

  task automatic send(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] op,
                      input logic [16:0] imm, input logic [26:0] tgt,
                      input logic [31:0] exp_data, input bit legal, input int max_wait,
                      output bit acc);
    ifc.req_valid  = 1'b1;
    ifc.req_kind   = k;
    ifc.req_rd     = rd;
    ifc.req_rs     = rs;
    ifc.req_rt     = rt;
    ifc.req_shamt  = sh;
    ifc.req_aluop  = op;
    ifc.req_imm    = imm;
    ifc.req_target = tgt;
    acc = 1'b0;
    for (int w = 0; w < max_wait && !acc; w++) begin
      @(negedge clk);
      if (ifc.req_ready) begin
        acc = 1'b1;
        if (legal) begin
          sb_q.push_back({exp_addr, exp_data});
          exp_addr++;
        end
      end
      @(posedge clk);
      #1;
    end
    ifc.req_valid = 1'b0;
  endtask

  // Legal-request shorthand; a request that never gets accepted is a failure.
  task automatic put(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] op,
                     input logic [16:0] imm, input logic [26:0] tgt, input logic [31:0] exp_data);
    bit acc;
    send(k, rd, rs, rt, sh, op, imm, tgt, exp_data, 1'b1, 8, acc);
    check("accepted", 32'(acc), 32'd1);
  endtask

  task automatic do_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    exp_addr = '0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_count", 32'(count), 32'd0);
    check("start_err", 32'(err), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n_acc;
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; exp_addr = '0;
    ifc.req_valid = 1'b0; ifc.req_kind = 4'd0; ifc.req_rd = '0; ifc.req_rs = '0;
    ifc.req_rt = '0; ifc.req_shamt = '0; ifc.req_aluop = '0; ifc.req_imm = '0;
    ifc.req_target = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check("rst_ready", 32'(ifc.req_ready), 32'd0);
    check("rst_wren", 32'(ifc.imem_wren), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", 32'(ifc.imem_addr), 32'd0);
    check("rst_data", ifc.imem_data, 32'h0);

    // 1: single ADDI
    do_start();
    put(4'd2, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 32'h28440005);
    idle(1);
    check("t1_count", 32'(count), 32'd1);

    // 2: back-to-back RTYPE, JAL, SETX, BEX (fills DEPTH=4)
    do_start();
    put(4'd1,  5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'd0, 27'd0,   32'h00C22000);
    put(4'd7,  5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd100, 32'h18000064);
    put(4'd11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd7,   32'hA8000007);
    put(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0,   32'hB0000000);
    idle(1);
    check("t2_count", 32'(count), 32'd4);

    // 3: INCSCORE, ADDI all-ones imm, R-type mul with junk imm, J max target
    do_start();
    put(4'd12, 5'd5, 5'd5, 5'd31, 5'd0, 5'd0, 17'd1, 27'h7FFFFFF, 32'h494A0001);
    put(4'd2,  5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 17'h1FFFF, 27'd0, 32'h2801FFFF);
    put(4'd1,  5'd1, 5'd2, 5'd3, 5'd3, 5'b00110, 17'h1FFFF, 27'h7FFFFFF, 32'h00443198);
    put(4'd5,  5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 17'h1FFFF, 27'h7FFFFFF, 32'h0FFFFFFF);

    // 3b: SW, LW, BNE, BLT
    do_start();
    put(4'd3, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 17'd3,  27'h7FFFFFF, 32'h38440003);
    put(4'd4, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 17'd3,  27'd0, 32'h40440003);
    put(4'd6, 5'd2, 5'd3, 5'd7, 5'd0, 5'd0, 17'h10, 27'd0, 32'h10860010);
    put(4'd9, 5'd2, 5'd3, 5'd0, 5'd9, 5'd0, 17'h10, 27'd0, 32'h30860010);

    // JR, NOP with junk fields, then finish while the NOP write is in flight
    do_start();
    put(4'd8, 5'd31, 5'd7, 5'd7, 5'd7, 5'd7, 17'h1FFFF, 27'h7FFFFFF, 32'h27C00000);
    put(4'd0, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'h7FFFFFF, 32'h00000000);
    finish = 1'b1;
    idle(1);
    finish = 1'b0;
    check("fin_busy", 32'(busy), 32'd0);
    check("fin_count", 32'(count), 32'd2);
    check("fin_ready", 32'(ifc.req_ready), 32'd0);

    // 4: stream 6 requests into DEPTH=4
    do_start();
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      send(4'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'(i), 27'd0, 32'h28000000 + 32'(i), 1'b1, 3, acc);
      if (acc) n_acc++;
      if (i == 3) begin
        check("full_ready", 32'(ifc.req_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd0);
      end
    end
    check("full_accepts", 32'(n_acc), 32'd4);
    check("full_count", 32'(count), 32'd4);
    finish = 1'b1;
    idle(1);
    finish = 1'b0;
    check("full_exit_busy", 32'(busy), 32'd0);

    // 5: illegal kind between two ADDIs
    do_start();
    put(4'd2, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 17'd2, 27'd0, 32'h28420002);
    send(4'd14, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 17'd1, 27'd1, 32'h0, 1'b0, 8, acc);
    check("illegal_consumed", 32'(acc), 32'd1);
    put(4'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 17'd9, 27'd0, 32'h28800009);
    idle(1);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_count", 32'(count), 32'd2);
    do_start();

    // 6a: start with a write in flight and a request offered
    put(4'd2, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 32'h28440005);
    void'(sb_q.pop_back());
    exp_addr = '0;
    ifc.req_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("drop_ready", 32'(ifc.req_ready), 32'd0);
    check("drop_wren", 32'(ifc.imem_wren), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    ifc.req_valid = 1'b0;
    check("drop_count", 32'(count), 32'd0);
    check("drop_busy", 32'(busy), 32'd1);
    idle(2);
    check("drop_count_later", 32'(count), 32'd0);

    // 6b: asynchronous reset while a write is presented
    put(4'd2, 5'd3, 5'd3, 5'd0, 5'd0, 5'd0, 17'd1, 27'd0, 32'h28C60001);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_wren", 32'(ifc.imem_wren), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    sb_q.delete();
    exp_addr = '0;
    idle(1);
    rst_n = 1'b1;
    idle(2);
    check("arst_idle_busy", 32'(busy), 32'd0);
    check("arst_idle_ready", 32'(ifc.req_ready), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
